// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - host, CAN-search and message-memory signal bundle for mem_access_ctrl
//
// Purpose: groups the three buses seen by the message-memory access controller.
// Ports (interface members):
//   host_req/host_rw/host_addr/host_wdata -> controller; host_ack/host_rdata <- controller
//   can_req/can_key -> controller; can_busy/can_done/can_hit/can_loc <- controller
//   mem_rw/mem_addr/mem_wdata <- controller; mem_rdata -> controller (combinational memory)
// Modports: slave = controller side, master = environment (host, CAN core, memory) side.
interface mem_access_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          host_req;
    logic          host_rw;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;

    logic          can_req;
    logic [DW-1:0] can_key;
    logic          can_busy;
    logic          can_done;
    logic          can_hit;
    logic [AW-1:0] can_loc;

    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  host_req, host_rw, host_addr, host_wdata,
        output host_ack, host_rdata,
        input  can_req, can_key,
        output can_busy, can_done, can_hit, can_loc,
        output mem_rw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output host_req, host_rw, host_addr, host_wdata,
        input  host_ack, host_rdata,
        output can_req, can_key,
        input  can_busy, can_done, can_hit, can_loc,
        input  mem_rw, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - CC770 message-memory port arbiter with interleaved CAN key search
//
// Purpose: shares one combinational-read memory port between host accesses and a
// cycle-by-cycle key scan from SEARCH_BASE to SEARCH_LAST, alternating fairly.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_access_ctrl_if.slave: host request/ack, CAN search request/result, memory port
module mem_access_ctrl #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int SEARCH_BASE = 0,
    parameter int SEARCH_LAST = 255
) (
    input  logic              clk,
    input  logic              rst,
    mem_access_ctrl_if.slave  bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SEARCH = 1'b1;

    localparam logic TURN_SEARCH = 1'b0;
    localparam logic TURN_HOST   = 1'b1;

    localparam logic [AW-1:0] BASE_ADDR = AW'(SEARCH_BASE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SEARCH_LAST);

    logic [0:0]    state;
    logic          turn;
    logic [AW-1:0] ptr;
    logic [DW-1:0] key;

    logic host_slot;
    logic scan_slot;
    logic match;

    // The ack cycle never grants, so a held request is not served twice.
    // Reset gating keeps the memory port idle while rst is asserted.
    assign host_slot = !rst && bus.host_req && !bus.host_ack &&
                       ((state == IDLE) || (turn == TURN_HOST));
    assign scan_slot = !rst && (state == SEARCH) && !host_slot;
    assign match     = (bus.mem_rdata == key);

    always_comb begin
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (host_slot) begin
            bus.mem_rw    = bus.host_rw;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
        end else if (scan_slot) begin
            bus.mem_addr  = ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            turn           <= TURN_SEARCH;
            ptr            <= '0;
            key            <= '0;
            bus.host_ack   <= 1'b0;
            bus.host_rdata <= '0;
            bus.can_busy   <= 1'b0;
            bus.can_done   <= 1'b0;
            bus.can_hit    <= 1'b0;
            bus.can_loc    <= '0;
        end else begin
            bus.host_ack <= host_slot;
            if (host_slot && bus.host_rw) begin
                bus.host_rdata <= bus.mem_rdata;
            end

            bus.can_done <= 1'b0;

            case (state)
                IDLE: begin
                    // A fresh search always begins with a scan slot.
                    turn <= TURN_SEARCH;
                    if (bus.can_req) begin
                        key          <= bus.can_key;
                        ptr          <= BASE_ADDR;
                        bus.can_busy <= 1'b1;
                        state        <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (host_slot) begin
                        turn <= TURN_SEARCH;
                    end else begin
                        turn <= TURN_HOST;
                        if (match) begin
                            bus.can_hit  <= 1'b1;
                            bus.can_loc  <= ptr;
                            bus.can_done <= 1'b1;
                            bus.can_busy <= 1'b0;
                            state        <= IDLE;
                        end else if (ptr == LAST_ADDR) begin
                            // Stop on the last address so ptr never wraps.
                            bus.can_hit  <= 1'b0;
                            bus.can_loc  <= '0;
                            bus.can_done <= 1'b1;
                            bus.can_busy <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard testbench for mem_access_ctrl
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   wr_low = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_access_ctrl_if #(.AW(8), .DW(8)) bus ();

    mem_access_ctrl #(
        .AW(8), .DW(8), .SEARCH_BASE(0), .SEARCH_LAST(255)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [7:0] mem [256];

    assign bus.mem_rdata = mem[bus.mem_addr];

    // Reset preloads the image: zeros everywhere, 0x5A only at 0x20.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h20] <= 8'h5A;
        end else if (!bus.mem_rw) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic       rw;
        logic [7:0] rdata;
        int         req_cyc;
        int         max_lat;
    } host_exp_t;

    typedef struct {
        logic       hit;
        logic [7:0] loc;
        int         done_cyc;
    } can_exp_t;

    host_exp_t host_q[$];
    can_exp_t  can_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && !bus.mem_rw) wr_low++;
            if (bus.host_ack) begin
                if (host_q.size() == 0) begin
                    check("host_ack_unexpected", 32'(bus.host_ack), 32'd0);
                end else begin
                    host_exp_t h;
                    h = host_q.pop_front();
                    check("host_ack_latency",
                          32'((cyc - h.req_cyc >= 1) && (cyc - h.req_cyc <= h.max_lat)), 32'd1);
                    if (h.rw) check("host_rdata", 32'(bus.host_rdata), 32'(h.rdata));
                end
            end
            if (bus.can_done) begin
                if (can_q.size() == 0) begin
                    check("can_done_unexpected", 32'(bus.can_done), 32'd0);
                end else begin
                    can_exp_t c;
                    c = can_q.pop_front();
                    check("can_done_cycle", 32'(cyc), 32'(c.done_cyc));
                    check("can_hit", 32'(bus.can_hit), 32'(c.hit));
                    check("can_loc", 32'(bus.can_loc), 32'(c.loc));
                    check("can_busy_at_done", 32'(bus.can_busy), 32'd0);
                end
            end
        end
    end

    task automatic host_access(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [7:0] exp_rdata, input int max_lat);
        host_exp_t h;
        bit acked;
        h.rw = rw; h.rdata = exp_rdata; h.req_cyc = cyc; h.max_lat = max_lat;
        host_q.push_back(h);
        bus.host_req   = 1'b1;
        bus.host_rw    = rw;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
        acked = 0;
        for (int i = 0; i < 8 && !acked; i++) begin
            tick();
            if (bus.host_ack) acked = 1;
        end
        bus.host_req = 1'b0;
        if (!acked) begin
            check("host_ack_timeout", 32'd0, 32'd1);
            void'(host_q.pop_back());
        end
    endtask

    task automatic search(input logic [7:0] key, input logic hit, input logic [7:0] loc,
                          input int lat);
        can_exp_t c;
        c.hit = hit; c.loc = loc; c.done_cyc = cyc + lat;
        can_q.push_back(c);
        bus.can_req = 1'b1;
        bus.can_key = key;
        tick();
        bus.can_req = 1'b0;
    endtask

    task automatic wait_search(input int bound);
        int n;
        n = 0;
        while (can_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (can_q.size() != 0) begin
            check("can_done_timeout", 32'd0, 32'd1);
            can_q.delete();
        end
    endtask

    initial begin
        int wr0;
        // Reset with a pending host write: no ack, port stays idle.
        bus.host_req   = 1'b1;
        bus.host_rw    = 1'b0;
        bus.host_addr  = 8'h33;
        bus.host_wdata = 8'hA5;
        bus.can_req    = 1'b0;
        bus.can_key    = 8'h00;
        tick(2);
        check("rst_host_ack", 32'(bus.host_ack), 32'd0);
        check("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
        check("rst_can_busy", 32'(bus.can_busy), 32'd0);
        check("rst_can_done", 32'(bus.can_done), 32'd0);
        check("rst_can_hit", 32'(bus.can_hit), 32'd0);
        check("rst_can_loc", 32'(bus.can_loc), 32'd0);
        check("rst_mem_rw", 32'(bus.mem_rw), 32'd1);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        rst = 1'b0;
        bus.host_req = 1'b0;
        tick();
        check("post_rst_no_ack", 32'(bus.host_ack), 32'd0);

        // Host write then read back at 0x10.
        wr0 = wr_low;
        host_access(1'b0, 8'h10, 8'h5A, 8'h00, 1);
        tick();
        host_access(1'b1, 8'h10, 8'h00, 8'h5A, 1);
        check("write_strobe_cycles", 32'(wr_low - wr0), 32'd1);
        tick();

        // Hit at 0x10 (0x20 also matches, lowest wins): done in cycle 18.
        search(8'h5A, 1'b1, 8'h10, 18);
        check("busy_after_start", 32'(bus.can_busy), 32'd1);
        wait_search(400);
        tick();

        // Miss across the full range: done in cycle 257.
        search(8'h77, 1'b0, 8'h00, 257);
        wait_search(400);
        tick();

        // Three host reads interleaved with a scan: done delayed by 3 cycles.
        search(8'h5A, 1'b1, 8'h10, 21);
        tick(2);
        host_access(1'b1, 8'h20, 8'h00, 8'h5A, 2);
        tick();
        host_access(1'b1, 8'h05, 8'h00, 8'h00, 2);
        tick();
        host_access(1'b1, 8'h10, 8'h00, 8'h5A, 2);
        wait_search(400);
        tick();

        // Simultaneous host and search request in IDLE: host first, scan unaffected.
        fork
            search(8'h5A, 1'b1, 8'h10, 18);
            host_access(1'b1, 8'h20, 8'h00, 8'h5A, 1);
        join
        wait_search(400);
        tick();

        // Reset in mid-scan: no done, busy drops next cycle.
        bus.can_req = 1'b1;
        bus.can_key = 8'h5A;
        tick();
        bus.can_req = 1'b0;
        tick(4);
        check("busy_mid_scan", 32'(bus.can_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_can_busy", 32'(bus.can_busy), 32'd0);
        check("abort_can_done", 32'(bus.can_done), 32'd0);
        tick(30);

        check("host_q_empty", 32'(host_q.size()), 32'd0);
        check("can_q_empty", 32'(can_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
